// File: rtl/lvds_frame_aligner.sv
// LVDS frame aligner: slips the word boundary until the sampled frame clock matches FRAME_PAT, then emits words.
// Latency: word_out/word_valid one cycle after the boundary; no backpressure (free-running serial stream).
module lvds_frame_aligner #(
    parameter int                WORD_W     = 12,
    parameter logic [WORD_W-1:0] FRAME_PAT  = 12'hFC0,
    parameter int                LOCK_CNT   = 8,
    parameter int                UNLOCK_CNT = 4
) (
    input  logic                      clk_in_int,
    input  logic                      clk_reset,
    input  logic                      en,
    input  logic                      din,
    input  logic                      fclk_smp,
    output logic [WORD_W-1:0]         word_out,
    output logic                      word_valid,
    output logic                      locked,
    output logic [$clog2(WORD_W)-1:0] slip_pos,
    output logic [7:0]                err_cnt
);
    localparam int PW = $clog2(WORD_W);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    localparam logic [PW-1:0] LAST = PW'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        VERIFY = 3'd2,
        LOCKED = 3'd3
    } state_t;

    state_t            state;
    logic [PW-1:0]     bit_cnt;
    logic [MW-1:0]     match_cnt;
    logic [UW-1:0]     miss_cnt;
    logic [WORD_W-1:0] d_sr;
    logic [WORD_W-1:0] f_sr;
    logic              slip_pend;
    logic              wb;
    logic              match;

    assign wb    = (bit_cnt == LAST);
    assign match = (f_sr == FRAME_PAT);

    always_ff @(posedge clk_in_int or posedge clk_reset) begin
        if (clk_reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            slip_pos   <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            d_sr       <= '0;
            f_sr       <= '0;
            slip_pend  <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= '0;
        end else begin
            d_sr       <= {d_sr[WORD_W-2:0], din};
            f_sr       <= {f_sr[WORD_W-2:0], fclk_smp};
            word_valid <= 1'b0;
            slip_pend  <= 1'b0;

            // A slip freezes bit_cnt for one cycle, pushing every later boundary one bit later.
            if (slip_pend && en) begin
                slip_pos <= (slip_pos == LAST) ? '0 : slip_pos + 1'b1;
                if (slip_pos == LAST && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end else if (wb) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (!en) begin
                state     <= IDLE;
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= SEARCH;
                    SEARCH: begin
                        if (wb) begin
                            if (match) begin
                                state     <= VERIFY;
                                match_cnt <= MW'(1);
                            end else begin
                                slip_pend <= 1'b1;
                            end
                        end
                    end
                    VERIFY: begin
                        if (wb) begin
                            if (!match) begin
                                state     <= SEARCH;
                                match_cnt <= '0;
                                slip_pend <= 1'b1;
                            end else if (int'(match_cnt) + 1 >= LOCK_CNT) begin
                                state     <= LOCKED;
                                match_cnt <= '0;
                                locked    <= 1'b1;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (wb) begin
                            if (!match && int'(miss_cnt) + 1 >= UNLOCK_CNT) begin
                                // Lost lock: resume searching from the current offset, no slip.
                                state    <= SEARCH;
                                miss_cnt <= '0;
                                locked   <= 1'b0;
                                if (err_cnt != 8'hFF)
                                    err_cnt <= err_cnt + 8'd1;
                            end else begin
                                miss_cnt   <= match ? '0 : miss_cnt + 1'b1;
                                word_out   <= d_sr;
                                word_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lvds_frame_aligner.sv
// Directed bench for lvds_frame_aligner: table of stream delays plus hand-built corner sequences.
module tb_lvds_frame_aligner;
    logic        clk_in_int = 1'b0;
    logic        clk_reset  = 1'b1;
    logic        en         = 1'b0;
    logic        din        = 1'b0;
    logic        fclk_smp   = 1'b0;
    logic [11:0] word_out;
    logic        word_valid;
    logic        locked;
    logic [3:0]  slip_pos;
    logic [7:0]  err_cnt;

    lvds_frame_aligner #(
        .WORD_W(12), .FRAME_PAT(12'hFC0), .LOCK_CNT(8), .UNLOCK_CNT(4)
    ) dut (
        .clk_in_int(clk_in_int),
        .clk_reset (clk_reset),
        .en        (en),
        .din       (din),
        .fclk_smp  (fclk_smp),
        .word_out  (word_out),
        .word_valid(word_valid),
        .locked    (locked),
        .slip_pos  (slip_pos),
        .err_cnt   (err_cnt)
    );

    always #5 clk_in_int = ~clk_in_int;

    typedef struct {
        int dly;
        int exp_slips;
        int exp_lock;
        int exp_pos;
    } vec_t;

    localparam logic [11:0] PAT = 12'hFC0;

    int          checks   = 0;
    int          failures = 0;
    int          k        = -1;
    int          delay    = 0;
    logic        stuck_low = 1'b0;
    logic        corrupt [0:63];
    logic [11:0] word_tbl [0:5];
    int          lock_edge, slips, early_wv;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    // Stream with frame boundaries delayed by 'delay' bits relative to slip_pos 0.
    task automatic drive(input int kk);
        int u, w, pos;
        logic [11:0] wd, fp;
        u   = kk + 1 + 48 - delay;
        w   = u / 12;
        pos = u % 12;
        wd  = word_tbl[w % 6];
        fp  = PAT;
        if (w < 64 && corrupt[w]) fp = ~fp;
        din      = wd[11-pos];
        fclk_smp = stuck_low ? 1'b0 : fp[11-pos];
    endtask

    function automatic int exp_word(input int e);
        return int'(word_tbl[((e + 48 - delay) / 12) % 6]);
    endfunction

    task automatic tick();
        @(posedge clk_in_int);
        #1;
        k++;
        drive(k + 1);
    endtask

    task automatic do_reset();
        en        = 1'b0;
        clk_reset = 1'b1;
        repeat (3) @(posedge clk_in_int);
        #3;
        clk_reset = 1'b0;
        k = -1;
        drive(0);
    endtask

    task automatic wait_lock(input int limit);
        int prev;
        prev = int'(slip_pos);
        slips = 0; lock_edge = -1; early_wv = 0;
        while (lock_edge < 0 && k < limit) begin
            tick();
            if (int'(slip_pos) != prev) slips++;
            prev = int'(slip_pos);
            if (word_valid) early_wv++;
            if (locked) lock_edge = k;
        end
    endtask

    task automatic start_and_lock(input int limit);
        while (k < 11) tick();
        en = 1'b1;
        wait_lock(limit);
    endtask

    initial begin
        vec_t vt [4];
        int   last, ever_locked, wv_low;
        logic exp_v;

        vt[0] = '{dly: 0,  exp_slips: 0,  exp_lock: 107, exp_pos: 0};
        vt[1] = '{dly: 1,  exp_slips: 1,  exp_lock: 120, exp_pos: 1};
        vt[2] = '{dly: 5,  exp_slips: 5,  exp_lock: 172, exp_pos: 5};
        vt[3] = '{dly: 11, exp_slips: 11, exp_lock: 250, exp_pos: 11};
        word_tbl[0] = 12'hABC; word_tbl[1] = 12'h123; word_tbl[2] = 12'h456;
        word_tbl[3] = 12'h789; word_tbl[4] = 12'hDEF; word_tbl[5] = 12'h0F0;
        for (int i = 0; i < 64; i++) corrupt[i] = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_in_int);
        #1;
        chk("rst_word_out", int'(word_out), 0);
        chk("rst_word_valid", int'(word_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_slip_pos", int'(slip_pos), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);

        // Table: delayed streams, lock timing, slip count and word sequence
        for (int t = 0; t < 4; t++) begin
            delay = vt[t].dly;
            do_reset();
            start_and_lock(500);
            chk("lock_edge", lock_edge, vt[t].exp_lock);
            chk("slip_count", slips, vt[t].exp_slips);
            chk("slip_pos", int'(slip_pos), vt[t].exp_pos);
            chk("err_cnt", int'(err_cnt), 0);
            chk("wv_before_lock", early_wv, 0);
            last = -1;
            while (k < lock_edge + 37) begin
                tick();
                exp_v = ((k - lock_edge) % 12 == 0);
                chk("word_valid", int'(word_valid), int'(exp_v));
                if (exp_v) begin
                    last = exp_word(k);
                    chk("word_out", int'(word_out), last);
                end else if (last >= 0) begin
                    chk("word_hold", int'(word_out), last);
                end
            end
        end

        // Lock-loss hysteresis: 3 bad, 1 good, 4 bad frames
        delay = 0;
        corrupt[13] = 1'b1; corrupt[14] = 1'b1; corrupt[15] = 1'b1;
        corrupt[17] = 1'b1; corrupt[18] = 1'b1; corrupt[19] = 1'b1; corrupt[20] = 1'b1;
        do_reset();
        start_and_lock(500);
        chk("hys_lock_edge", lock_edge, 107);
        while (k < 203) begin
            tick();
            if (k == 119) chk("hys_miss1_word", int'(word_out), exp_word(119));
            if (k == 143) chk("hys_miss3_locked", int'(locked), 1);
            if (k == 155) chk("hys_good_valid", int'(word_valid), 1);
            if (k == 191) begin
                chk("hys_miss7_locked", int'(locked), 1);
                chk("hys_miss7_valid", int'(word_valid), 1);
            end
        end
        chk("hys_exit_locked", int'(locked), 0);
        chk("hys_exit_valid", int'(word_valid), 0);
        chk("hys_exit_err", int'(err_cnt), 1);
        for (int i = 0; i < 64; i++) corrupt[i] = 1'b0;

        // Stuck frame clock with en high through reset release
        stuck_low = 1'b1;
        do_reset();
        en = 1'b1;
        ever_locked = 0;
        while (k < 40000) begin
            tick();
            if (locked) ever_locked = 1;
            if (k == 11) chk("stuck_pos_e11", int'(slip_pos), 0);
            if (k == 12) chk("stuck_pos_e12", int'(slip_pos), 1);
            if (k == 154) chk("stuck_err_e154", int'(err_cnt), 0);
            if (k == 155) begin
                chk("stuck_err_e155", int'(err_cnt), 1);
                chk("stuck_pos_e155", int'(slip_pos), 0);
            end
            if (k == 39778) chk("stuck_err_e39778", int'(err_cnt), 254);
            if (k == 39779) chk("stuck_err_e39779", int'(err_cnt), 255);
        end
        chk("stuck_err_sat", int'(err_cnt), 255);
        chk("stuck_never_locked", ever_locked, 0);
        stuck_low = 1'b0;

        // en dropped for 20 cycles while locked, then relock without slips
        delay = 5;
        do_reset();
        start_and_lock(500);
        chk("en_lock_edge", lock_edge, 172);
        while (k < 180) tick();
        en = 1'b0;
        tick();
        chk("en_off_locked", int'(locked), 0);
        chk("en_off_valid", int'(word_valid), 0);
        chk("en_off_pos", int'(slip_pos), 5);
        wv_low = 0;
        while (k < 200) begin
            tick();
            if (word_valid || locked) wv_low++;
        end
        chk("en_off_quiet", wv_low, 0);
        en = 1'b1;
        wait_lock(500);
        chk("relock_edge", lock_edge, 292);
        chk("relock_slips", slips, 0);
        chk("relock_pos", int'(slip_pos), 5);
        while (k < 304) tick();
        chk("relock_valid", int'(word_valid), 1);
        chk("relock_word", int'(word_out), exp_word(304));

        // Asynchronous reset in the boundary cycle while locked
        while (k < 315) tick();
        #2;
        clk_reset = 1'b1;
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_word_out", int'(word_out), 0);
        chk("arst_pos", int'(slip_pos), 0);
        chk("arst_err", int'(err_cnt), 0);
        @(posedge clk_in_int);
        #1;
        chk("arst_no_valid", int'(word_valid), 0);
        delay = 0;
        do_reset();
        start_and_lock(500);
        chk("arst_relock_edge", lock_edge, 107);
        chk("arst_relock_slips", slips, 0);
        chk("arst_relock_pos", int'(slip_pos), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lvds_frame_aligner.md
LVDS_FRAME_ALIGNER -- requirements
Module: lvds_frame_aligner

Interface
REQ-001 Parameter WORD_W, default 12, deserialized word width in bits (4..16).
REQ-002 Parameter FRAME_PAT, default 12'hFC0, expected frame-clock pattern in one word window, MSB first.
REQ-003 Parameter LOCK_CNT, default 8, consecutive matching boundaries needed to declare lock.
REQ-004 Parameter UNLOCK_CNT, default 4, consecutive mismatching boundaries that drop lock.
REQ-005 clk_in_int  input  1  bit clock from the LVDS clock input buffer; all logic on its rising edge.
REQ-006 clk_reset  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  alignment/capture enable, synchronous to clk_in_int.
REQ-008 din  input  1  serial ADC data bit, one bit per clk_in_int cycle.
REQ-009 fclk_smp  input  1  frame clock sampled as data on clk_in_int.
REQ-010 word_out  output  WORD_W  deserialized data word, first-received bit in MSB.
REQ-011 word_valid  output  1  one-cycle strobe qualifying word_out.
REQ-012 locked  output  1  high while the state machine is in LOCKED.
REQ-013 slip_pos  output  $clog2(WORD_W)  current word-boundary offset, 0..WORD_W-1.
REQ-014 err_cnt  output  8  saturating alignment-error counter.

Function
REQ-015 Every cycle: d_sr <= {d_sr[WORD_W-2:0], din}; f_sr <= {f_sr[WORD_W-2:0], fclk_smp}.
REQ-016 bit_cnt counts 0..WORD_W-1, then wraps to 0. The word boundary (wb) is the cycle in which bit_cnt == WORD_W-1.
REQ-017 At wb, match is (f_sr == FRAME_PAT), using the registered f_sr value at the start of that cycle.
REQ-018 A slip holds bit_cnt for one cycle, which delays every later wb by one bit. Each slip sets slip_pos <= (slip_pos+1) mod WORD_W.
REQ-019 States: IDLE, SEARCH, VERIFY, LOCKED, registered; any other encoding recovers to IDLE on the next cycle.
REQ-020 en == 0 in any state: next state IDLE; match_cnt and miss_cnt cleared; slip_pos and err_cnt retained.
REQ-021 IDLE: en == 1 -> SEARCH on the next cycle.
REQ-022 SEARCH, wb with match -> VERIFY with match_cnt=1.
REQ-023 SEARCH, wb with mismatch -> slip, stay in SEARCH.
REQ-024 SEARCH, slip that wraps slip_pos from WORD_W-1 to 0 -> err_cnt +1.
REQ-025 VERIFY, wb with match -> match_cnt +1; when match_cnt reaches LOCK_CNT -> LOCKED.
REQ-026 VERIFY, wb with mismatch -> SEARCH, match_cnt=0, plus one slip.
REQ-027 LOCKED, wb with match -> miss_cnt=0.
REQ-028 LOCKED, wb with mismatch -> miss_cnt +1; when miss_cnt reaches UNLOCK_CNT -> SEARCH with miss_cnt=0 and err_cnt +1. No slip is issued on that transition.
REQ-029 In LOCKED, every wb that does not cause a transition out of LOCKED loads word_out <= d_sr (the registered value at the start of the wb cycle) and pulses word_valid for exactly one cycle. Latency is 1 cycle after wb.
REQ-030 word_valid is never asserted outside LOCKED, nor on the wb that exits LOCKED.
REQ-031 word_out holds its last value between strobes.
REQ-032 locked is registered: it rises the cycle after the transition into LOCKED and falls the cycle after the transition out of LOCKED.
REQ-033 err_cnt saturates at 8'hFF and never wraps.
REQ-034 A slip and a wb never coincide: the slip is applied in the cycle following the deciding wb.

Reset
REQ-035 While clk_reset is high: state=IDLE, bit_cnt=0, slip_pos=0, match_cnt=0, miss_cnt=0, d_sr=0, f_sr=0, word_out=0, word_valid=0, locked=0, err_cnt=0.
REQ-036 clk_reset asserted mid-operation, including in LOCKED or during a slip, takes effect immediately. No word_valid pulse is generated after its assertion.
REQ-037 Operation resumes on the first rising edge after clk_reset deasserts; with en high, IDLE -> SEARCH on that edge.

Verification
REQ-038 Aligned stream: FRAME_PAT repeating and phase-matched to slip_pos=0, en=1 -> no slips; locked rises 1 cycle after the 8th matching wb; slip_pos=0; err_cnt=0.
REQ-039 Same stream delayed by 5 bits -> exactly 5 slips, slip_pos=5, then lock; word_out sequence equals the transmitted words 0xABC, 0x123, ...; one word_valid per 12 cycles.
REQ-040 fclk_smp stuck low, en=1 -> never locks; err_cnt increments every 12 slips and saturates at 0xFF.
REQ-041 Locked, then inject 3 corrupted frames, then 1 good frame, then 4 corrupted frames -> locked stays high through the first 3 misses; locked drops after the 4th consecutive miss; err_cnt +1; no word_valid on the exiting wb.
REQ-042 en dropped for 20 cycles while LOCKED -> IDLE; locked=0 and word_valid=0 the cycle after; slip_pos is retained; on en=1 the block relocks with 0 slips.
REQ-043 clk_reset pulsed while LOCKED -> all outputs 0 asynchronously; after release the block relocks from slip_pos=0.
